// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core.
// Sequences IF/ID/EX/MEM/WB per opcode and drives the datapath enables and
// mux selects. IF and MEM each last MEM_WAIT+1 cycles. An ECALL with
// ecall_halt set parks the core in a sticky HALT state until reset.
module multicycle_control_fsm #(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       alu_bcond,
    input  logic       ecall_halt,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       alu_ctrl_op,
    output logic       is_halted
);

    // Counter wide enough to hold MEM_WAIT (at least one bit when MEM_WAIT is 0).
    localparam int WCW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_WAIT);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EX     = 4'd2,
        S_MEM    = 4'd3,
        S_WB     = 4'd4,
        S_JUMP   = 4'd5,
        S_JALR   = 4'd6,
        S_ECALL  = 4'd7,
        S_NEXT   = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t         state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           wait_last_s;

    assign wait_last_s = (wait_cnt_q == WAIT_LAST);

    // State and wait counter registers; reset restarts fetch from a clean counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IF;
            wait_cnt_q <= {WCW{1'b0}};
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state selection and wait counter update.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_IF: begin
                if (wait_last_s) state_d = S_ID;
                else             state_d = S_IF;
            end
            S_ID: begin
                case (opcode)
                    OP_JAL:    state_d = S_JUMP;
                    OP_ECALL:  state_d = S_ECALL;
                    OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR:
                               state_d = S_EX;
                    default:   state_d = S_NEXT;
                endcase
            end
            S_EX: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    OP_R, OP_I:        state_d = S_WB;
                    OP_JALR:           state_d = S_JALR;
                    default:           state_d = S_IF;   // BRANCH resolves here
                endcase
            end
            S_MEM: begin
                if (!wait_last_s)          state_d = S_MEM;
                else if (opcode == OP_LOAD) state_d = S_WB;
                else                       state_d = S_IF;
            end
            S_ECALL: begin
                if (ecall_halt) state_d = S_HALT;
                else            state_d = S_IF;
            end
            S_HALT:  state_d = S_HALT;
            S_WB, S_JUMP, S_JALR, S_NEXT: state_d = S_IF;
            default: state_d = S_IF;
        endcase

        // Counter only runs while dwelling in IF/MEM; any state change clears it.
        if (state_d != state_q) begin
            wait_cnt_d = {WCW{1'b0}};
        end else if ((state_q == S_IF) || (state_q == S_MEM)) begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // Moore output decode; everything is forced low while reset is asserted.
    always_comb begin
        pc_write    = 1'b0;
        pc_source   = 2'b00;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        mem_to_reg  = 2'b00;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_ctrl_op = 1'b0;
        is_halted   = 1'b0;
        if (reset) begin
            pc_write = 1'b0;
        end else begin
            case (state_q)
                S_IF: begin
                    i_or_d   = 1'b0;
                    mem_read = 1'b1;
                    ir_write = wait_last_s;
                end
                S_ID: begin
                    alu_src_a   = 1'b0;
                    alu_src_b   = 2'b10;
                    alu_ctrl_op = 1'b0;
                end
                S_EX: begin
                    alu_src_a   = 1'b1;
                    alu_ctrl_op = 1'b1;
                    if ((opcode == OP_R) || (opcode == OP_BRANCH)) alu_src_b = 2'b00;
                    else                                           alu_src_b = 2'b10;
                    if (opcode == OP_BRANCH) begin
                        pc_write  = 1'b1;
                        pc_source = alu_bcond ? 2'b01 : 2'b00;
                    end else begin
                        pc_write  = 1'b0;
                    end
                end
                S_MEM: begin
                    i_or_d = 1'b1;
                    if (opcode == OP_STORE) begin
                        mem_write = wait_last_s;
                        pc_write  = wait_last_s;
                    end else begin
                        mem_read  = 1'b1;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
                    pc_write   = 1'b1;
                    pc_source  = 2'b00;
                end
                S_JUMP: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b10;
                    pc_write   = 1'b1;
                    pc_source  = 2'b01;
                end
                S_JALR: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b10;
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                end
                S_ECALL: begin
                    pc_write  = ~ecall_halt;
                    pc_source = 2'b00;
                end
                S_NEXT: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b00;
                end
                S_HALT: begin
                    is_halted = 1'b1;
                end
                default: begin
                    pc_write = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: two instances (MEM_WAIT 0 and 2) checked
// cycle by cycle against per-instruction output traces built from the
// instruction-class rules, plus a fixed vector table of CPI expectations.
module tb_multicycle_control_fsm;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_ctrl_op;
        logic       is_halted;
    } outs_t;

    typedef struct {
        logic [6:0] opc;
        logic       bc;
        logic       eh;
        int         w;        // 0 -> MEM_WAIT 0 instance, 1 -> MEM_WAIT 2 instance
        int         exp_len;  // cycles up to retire (pc_write) or first HALT cycle
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b1, rst1 = 1'b1;
    logic [6:0] opc0 = 7'd0, opc1 = 7'd0;
    logic       bc0 = 1'b0, bc1 = 1'b0, eh0 = 1'b0, eh1 = 1'b0;

    logic       a_pcw [2];
    logic [1:0] a_pcs [2];
    logic       a_iod [2];
    logic       a_mr  [2];
    logic       a_mw  [2];
    logic       a_irw [2];
    logic [1:0] a_mtr [2];
    logic       a_rw  [2];
    logic       a_sa  [2];
    logic [1:0] a_sb  [2];
    logic       a_aop [2];
    logic       a_hlt [2];

    multicycle_control_fsm #(.MEM_WAIT(0)) dut0 (
        .clk(clk), .reset(rst0), .opcode(opc0), .alu_bcond(bc0), .ecall_halt(eh0),
        .pc_write(a_pcw[0]), .pc_source(a_pcs[0]), .i_or_d(a_iod[0]), .mem_read(a_mr[0]),
        .mem_write(a_mw[0]), .ir_write(a_irw[0]), .mem_to_reg(a_mtr[0]), .reg_write(a_rw[0]),
        .alu_src_a(a_sa[0]), .alu_src_b(a_sb[0]), .alu_ctrl_op(a_aop[0]), .is_halted(a_hlt[0])
    );

    multicycle_control_fsm #(.MEM_WAIT(2)) dut1 (
        .clk(clk), .reset(rst1), .opcode(opc1), .alu_bcond(bc1), .ecall_halt(eh1),
        .pc_write(a_pcw[1]), .pc_source(a_pcs[1]), .i_or_d(a_iod[1]), .mem_read(a_mr[1]),
        .mem_write(a_mw[1]), .ir_write(a_irw[1]), .mem_to_reg(a_mtr[1]), .reg_write(a_rw[1]),
        .alu_src_a(a_sa[1]), .alu_src_b(a_sb[1]), .alu_ctrl_op(a_aop[1]), .is_halted(a_hlt[1])
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cur_w   = -1;
    outs_t exp_q[$];
    vec_t  tbl[16];

    function automatic outs_t act(input int w);
        outs_t o;
        o.pc_write    = a_pcw[w];
        o.pc_source   = a_pcs[w];
        o.i_or_d      = a_iod[w];
        o.mem_read    = a_mr[w];
        o.mem_write   = a_mw[w];
        o.ir_write    = a_irw[w];
        o.mem_to_reg  = a_mtr[w];
        o.reg_write   = a_rw[w];
        o.alu_src_a   = a_sa[w];
        o.alu_src_b   = a_sb[w];
        o.alu_ctrl_op = a_aop[w];
        o.is_halted   = a_hlt[w];
        return o;
    endfunction

    task automatic chk(input string name, input int idx, input outs_t got, input outs_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %b required %b (pcw pcs iod mr mw irw mtr rw sa sb aop hlt)",
                     name, idx, got, exp);
        end
    endtask

    // Expected per-cycle outputs of one instruction, from IF to retire (or into HALT).
    task automatic build(input logic [6:0] opc, input logic bc, input logic eh, input int mw);
        outs_t o;
        bit uses_ex;
        exp_q.delete();
        for (int i = 0; i <= mw; i++) begin
            o = '0; o.mem_read = 1'b1; o.ir_write = (i == mw); exp_q.push_back(o);
        end
        o = '0; o.alu_src_b = 2'b10; exp_q.push_back(o);
        uses_ex = (opc == OP_R) || (opc == OP_I) || (opc == OP_LOAD) || (opc == OP_STORE) ||
                  (opc == OP_BRANCH) || (opc == OP_JALR);
        if (uses_ex) begin
            o = '0; o.alu_src_a = 1'b1; o.alu_ctrl_op = 1'b1;
            o.alu_src_b = ((opc == OP_R) || (opc == OP_BRANCH)) ? 2'b00 : 2'b10;
            if (opc == OP_BRANCH) begin
                o.pc_write = 1'b1; o.pc_source = bc ? 2'b01 : 2'b00;
            end
            exp_q.push_back(o);
        end
        if (opc == OP_LOAD) begin
            for (int i = 0; i <= mw; i++) begin
                o = '0; o.i_or_d = 1'b1; o.mem_read = 1'b1; exp_q.push_back(o);
            end
        end
        if (opc == OP_STORE) begin
            for (int i = 0; i <= mw; i++) begin
                o = '0; o.i_or_d = 1'b1; o.mem_write = (i == mw); o.pc_write = (i == mw);
                exp_q.push_back(o);
            end
        end
        if ((opc == OP_R) || (opc == OP_I) || (opc == OP_LOAD)) begin
            o = '0; o.reg_write = 1'b1; o.pc_write = 1'b1;
            o.mem_to_reg = (opc == OP_LOAD) ? 2'b01 : 2'b00;
            exp_q.push_back(o);
        end
        if ((opc == OP_JAL) || (opc == OP_JALR)) begin
            o = '0; o.reg_write = 1'b1; o.mem_to_reg = 2'b10; o.pc_write = 1'b1;
            o.pc_source = (opc == OP_JAL) ? 2'b01 : 2'b10;
            exp_q.push_back(o);
        end
        if (opc == OP_ECALL) begin
            o = '0; o.pc_write = ~eh; exp_q.push_back(o);
            if (eh) begin
                for (int i = 0; i < 3; i++) begin
                    o = '0; o.is_halted = 1'b1; exp_q.push_back(o);
                end
            end
        end
        if (!uses_ex && (opc != OP_JAL) && (opc != OP_ECALL)) begin
            o = '0; o.pc_write = 1'b1; exp_q.push_back(o);
        end
    endtask

    task automatic set_in(input int w, input logic [6:0] opc, input logic bc, input logic eh);
        if (w == 0) begin opc0 = opc; bc0 = bc; eh0 = eh; end
        else        begin opc1 = opc; bc1 = bc; eh1 = eh; end
    endtask

    // Called on a falling edge: reset both DUTs for one rising edge, release only w.
    task automatic do_reset(input int w);
        rst0 = 1'b1; rst1 = 1'b1;
        #1;
        chk("reset_zero", w, act(w), '0);
        @(negedge clk);
        if (w == 0) rst0 = 1'b0;
        else        rst1 = 1'b0;
        cur_w = w;
    endtask

    // Runs one instruction starting in the first IF cycle; called on a falling edge.
    task automatic run(input int w, input logic [6:0] opc, input logic bc, input logic eh,
                       input int exp_len, input string name);
        outs_t got;
        int seen;
        if (w != cur_w) do_reset(w);
        build(opc, bc, eh, (w == 0) ? 0 : 2);
        set_in(w, opc, bc, eh);
        seen = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            #1;
            got = act(w);
            chk(name, i, got, exp_q[i]);
            if ((seen < 0) && (got.pc_write || got.is_halted)) seen = i + 1;
            @(negedge clk);
        end
        if (exp_len > 0) begin
            n_tests++;
            if (seen != exp_len) begin
                n_fail++;
                $display("FAIL %s_len: got %0d cycles required %0d", name, seen, exp_len);
            end
        end
    endtask

    initial begin
        tbl[0]  = '{OP_R,      1'b0, 1'b0, 0, 4};
        tbl[1]  = '{OP_I,      1'b0, 1'b0, 0, 4};
        tbl[2]  = '{OP_LOAD,   1'b0, 1'b0, 0, 5};
        tbl[3]  = '{OP_STORE,  1'b0, 1'b0, 0, 4};
        tbl[4]  = '{OP_BRANCH, 1'b1, 1'b0, 0, 3};
        tbl[5]  = '{OP_BRANCH, 1'b0, 1'b0, 0, 3};
        tbl[6]  = '{OP_JAL,    1'b0, 1'b0, 0, 3};
        tbl[7]  = '{OP_JALR,   1'b0, 1'b0, 0, 4};
        tbl[8]  = '{OP_LUI,    1'b0, 1'b0, 0, 3};
        tbl[9]  = '{OP_ECALL,  1'b0, 1'b0, 0, 3};
        tbl[10] = '{OP_ECALL,  1'b0, 1'b1, 0, 4};
        tbl[11] = '{OP_LOAD,   1'b0, 1'b0, 1, 9};
        tbl[12] = '{OP_STORE,  1'b0, 1'b0, 1, 8};
        tbl[13] = '{OP_BRANCH, 1'b1, 1'b0, 1, 5};
        tbl[14] = '{OP_JAL,    1'b0, 1'b0, 1, 5};
        tbl[15] = '{OP_ECALL,  1'b1, 1'b1, 1, 6};

        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            run(tbl[i].w, tbl[i].opc, tbl[i].bc, tbl[i].eh, tbl[i].exp_len, $sformatf("vec%0d", i));
            if ((tbl[i].opc == OP_ECALL) && tbl[i].eh) do_reset(tbl[i].w);
        end

        // Reset during MEM (second wait cycle) of a load, then a clean ADD.
        if (cur_w != 1) do_reset(1);
        set_in(1, OP_LOAD, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        do_reset(1);
        run(1, OP_R, 1'b0, 1'b0, 6, "add_after_mem_reset");

        // Reset during IF with a partially counted wait.
        set_in(1, OP_STORE, 1'b0, 1'b0);
        repeat (1) @(negedge clk);
        do_reset(1);
        run(1, OP_STORE, 1'b0, 1'b0, 8, "sw_after_if_reset");

        // HALT is left only via reset.
        run(0, OP_ECALL, 1'b0, 1'b1, 4, "halt_seq");
        do_reset(0);
        run(0, OP_JALR, 1'b0, 1'b0, 4, "jalr_after_halt");

        // Randomised instruction stream on both instances.
        for (int n = 0; n < 60; n++) begin
            logic [6:0] opc;
            int w;
            logic bc, eh;
            case ($urandom_range(0, 9))
                0: opc = OP_R;
                1: opc = OP_I;
                2: opc = OP_LOAD;
                3: opc = OP_STORE;
                4: opc = OP_BRANCH;
                5: opc = OP_JAL;
                6: opc = OP_JALR;
                7: opc = OP_ECALL;
                default: opc = 7'($urandom_range(0, 127));
            endcase
            w  = $urandom_range(0, 1);
            bc = 1'($urandom_range(0, 1));
            eh = ($urandom_range(0, 5) == 0);
            run(w, opc, bc, eh, 0, "rand");
            if ((opc == OP_ECALL) && eh) do_reset(w);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
